// File: rtl/div_pkg.sv
// Shared definitions for the iterative divide controller: FSM state
// encodings, default width, the divide-by-zero quotient and the operand
// magnitude helper.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Widest operand the magnitude helper and DBZ constant can serve.
    localparam int DIV_MAX_WIDTH = 64;

    // Controller states, kept as plain constants for the legacy decoders.
    typedef logic [1:0] div_state_t;
    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t ITER = 2'd1;
    localparam div_state_t FIX  = 2'd2;
    localparam div_state_t DONE = 2'd3;

    // Quotient reported for a zero divisor; users slice the low WIDTH bits.
    localparam logic [DIV_MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

    // Magnitude of a width-bit operand held zero-extended in 'value'.
    // Signed negatives are negated modulo 2^width, so the most negative
    // value maps onto itself. Only the low 'width' bits of the result matter.
    function automatic logic [DIV_MAX_WIDTH-1:0] abs_mag(
        input logic [DIV_MAX_WIDTH-1:0] value,
        input int unsigned              width,
        input logic                     is_signed
    );
        logic [DIV_MAX_WIDTH-1:0] top;
        top = value >> (width - 1);
        return (is_signed && top[0]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// Combinational radix-2 restoring divide slice: retires STEPS quotient
// bits per evaluation. The dividend magnitude is shifted out of the top of
// the quotient register into the remainder while quotient bits shift in.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int STEPS = 1
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] mag,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;

    // Unrolled shift / compare / conditional subtract, STEPS times.
    always_comb begin
        // NOTE: blocking assignments chain each unrolled step onto the
        // previous one, and every variable gets a default first so no latch
        // is inferred.
        rem_out = rem_in;
        quo_out = quo_in;
        shifted = '0;
        for (int i = 0; i < STEPS; i++) begin
            shifted = (rem_out << 1) | (WIDTH + 1)'(quo_out[WIDTH-1]);
            quo_out = {quo_out[WIDTH-2:0], 1'b0};
            if (shifted >= {1'b0, mag}) begin
                shifted    = shifted - {1'b0, mag};
                quo_out[0] = 1'b1;
            end
            rem_out = shifted;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller. Latches one request, runs WIDTH/STEPS
// restoring iterations, applies the sign fix-up and pulses done for one
// cycle. busy stalls the main control FSM; cancel flushes without a result.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int STEPS = 1   // 1, 2 or 4; must divide WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - STEPS);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic             dvd_neg;    // signed op with negative dividend
    logic             dvs_neg;    // signed op with negative divisor
    logic             dbz_pending;
    logic [WIDTH-1:0] dvd_orig;   // raw dividend, returned as r on /0
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem_acc;    // one spare bit holds the shifted value
    logic [WIDTH-1:0] quo_acc;

    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    assign dividend_mag = WIDTH'(abs_mag(DIV_MAX_WIDTH'(dividend), WIDTH, is_signed));
    assign divisor_mag  = WIDTH'(abs_mag(DIV_MAX_WIDTH'(divisor),  WIDTH, is_signed));

    // Quotient is negative when operand signs differ; remainder follows
    // the dividend. Negation wraps, which yields MIN / -1 = MIN, r = 0.
    assign quo_fixed = (dvd_neg ^ dvs_neg) ? -quo_acc : quo_acc;
    assign rem_fixed = dvd_neg ? -rem_acc[WIDTH-1:0] : rem_acc[WIDTH-1:0];

    assign busy = (state == ITER) || (state == FIX);
    assign done = (state == DONE);

    div_step #(
        .WIDTH (WIDTH),
        .STEPS (STEPS)
    ) u_step (
        .rem_in  (rem_acc),
        .quo_in  (quo_acc),
        .mag     (dvs_mag),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    // Control FSM, operand capture, iteration datapath and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dbz_pending <= 1'b0;
            dvd_orig    <= '0;
            dvs_mag     <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (cancel) begin
            // Flush: drop the operation and any same-cycle start; results hold.
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd_neg     <= is_signed & dividend[WIDTH-1];
                        dvs_neg     <= is_signed & divisor[WIDTH-1];
                        dvd_orig    <= dividend;
                        dvs_mag     <= divisor_mag;
                        quo_acc     <= dividend_mag;
                        rem_acc     <= '0;
                        count       <= '0;
                        dbz_pending <= (divisor == '0);
                        state       <= (divisor == '0) ? FIX : ITER;
                    end else begin
                        state <= IDLE;
                    end
                end
                ITER: begin
                    rem_acc <= rem_next;
                    quo_acc <= quo_next;
                    count   <= count + CNT_STEP;
                    if (count == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_pending) begin
                        q           <= DBZ_QUOTIENT[WIDTH-1:0];
                        r           <= dvd_orig;
                        div_by_zero <= 1'b1;
                    end else begin
                        q           <= quo_fixed;
                        r           <= rem_fixed;
                        div_by_zero <= 1'b0;
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a scoreboard queue receives the expected
// result when each request is issued and is drained when done pulses.
module tb_div_sequencer;

    localparam int WIDTH = 32;
    localparam int STEPS = 1;
    localparam int LAT   = WIDTH / STEPS + 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               lat;
        string            tag;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors     = 0;
    int   miscompares = 0;

    div_sequencer #(
        .WIDTH (WIDTH),
        .STEPS (STEPS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result from native 64-bit arithmetic (truncating division).
    function automatic exp_t model(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t   e;
        longint sa, sd, qq, rr;
        e.lat = LAT;
        e.dbz = 1'b0;
        e.tag = "";
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sd = longint'($signed(b));
            end else begin
                sa = longint'({32'b0, a});
                sd = longint'({32'b0, b});
            end
            qq  = sa / sd;
            rr  = sa % sd;
            e.q = qq[WIDTH-1:0];
            e.r = rr[WIDTH-1:0];
        end
        return e;
    endfunction

    // Called at a falling edge; start is sampled by the next rising edge
    // (edge 0) and the task returns at the falling edge of cycle 1.
    task automatic start_op(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit push, input string tag);
        exp_t e;
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        if (push) begin
            e     = model(sgn, a, b);
            e.tag = tag;
            scoreboard.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        is_signed = ~sgn;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Waits (bounded) for done, checking busy along the way, then compares
    // against the oldest scoreboard entry. Optionally pulses start with other
    // operands at inject_cycle, which must be ignored. Returns in the done cycle.
    task automatic wait_done(input int inject_cycle, input logic [WIDTH-1:0] inj_a, input logic [WIDTH-1:0] inj_b);
        exp_t e;
        int   n;
        bit   seen;
        check("sb_nonempty", 64'(scoreboard.size() != 0), 64'd1);
        if (scoreboard.size() == 0) return;
        e    = scoreboard.pop_front();
        n    = 1;
        seen = 1'b0;
        while (n <= e.lat + 4 && !seen) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (n == 1 || n == e.lat - 1) check($sformatf("%s_busy_c%0d", e.tag, n), 64'(busy), 64'd1);
                if (n == inject_cycle) begin
                    start     = 1'b1;
                    is_signed = 1'b0;
                    dividend  = inj_a;
                    divisor   = inj_b;
                end
                @(posedge clock);
                @(negedge clock);
                start = 1'b0;
                n++;
            end
        end
        check({e.tag, "_done_seen"}, 64'(seen), 64'd1);
        check({e.tag, "_latency"}, 64'(n), 64'(e.lat));
        check({e.tag, "_q"}, 64'(q), 64'(e.q));
        check({e.tag, "_r"}, 64'(r), 64'(e.r));
        check({e.tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        check({e.tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    // Advances n cycles and counts any busy or done seen meanwhile.
    task automatic quiet_cycles(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    initial begin
        int bad;
        reset     = 1'b1;
        start     = 1'b0;
        cancel    = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", 64'(q), 64'd0);
        check("rst_r", 64'(r), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Main function over sign combinations and corner operands.
        start_op(1'b0, 32'd100, 32'd7, 1'b1, "u100_7");          wait_done(0, '0, '0);
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");     wait_done(0, '0, '0);
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, "s7_-2");     wait_done(0, '0, '0);
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf"); wait_done(0, '0, '0);
        start_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, "u_max_1");   wait_done(0, '0, '0);
        start_op(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b1, "s_dbz");     wait_done(0, '0, '0);
        start_op(1'b0, 32'h1234_5678, 32'd0, 1'b1, "u_dbz");     wait_done(0, '0, '0);

        // Back-to-back: start issued in the DONE cycle; a start mid-op is ignored.
        start_op(1'b0, 32'd100, 32'd7, 1'b1, "b2b_first");       wait_done(0, '0, '0);
        start_op(1'b0, 32'd9, 32'd4, 1'b1, "b2b_second");        wait_done(10, 32'd1000, 32'd3);
        @(negedge clock);
        check("b2b_idle_done", 64'(done), 64'd0);
        check("b2b_idle_busy", 64'(busy), 64'd0);

        // Cancel at cycle 10 (with a competing start) after a 100/7 result.
        start_op(1'b0, 32'd100, 32'd7, 1'b1, "pre_cancel");      wait_done(0, '0, '0);
        @(negedge clock);
        start_op(1'b0, 32'd50, 32'd5, 1'b0, "");
        repeat (9) begin
            @(posedge clock);
            @(negedge clock);
        end
        cancel    = 1'b1;
        start     = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        @(posedge clock);
        @(negedge clock);
        cancel = 1'b0;
        start  = 1'b0;
        check("cancel_busy_c11", 64'(busy), 64'd0);
        quiet_cycles(LAT + 6, bad);
        check("cancel_quiet", 64'(bad), 64'd0);
        check("cancel_keep_q", 64'(q), 64'd14);
        check("cancel_keep_r", 64'(r), 64'd2);
        check("cancel_keep_dbz", 64'(div_by_zero), 64'd0);

        // Asynchronous reset at cycle 10 of the same operation.
        start_op(1'b0, 32'd50, 32'd5, 1'b0, "");
        repeat (9) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_q", 64'(q), 64'd0);
        check("midrst_r", 64'(r), 64'd0);
        check("midrst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        quiet_cycles(LAT + 6, bad);
        check("midrst_quiet", 64'(bad), 64'd0);

        // A few random operands in both modes.
        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? WIDTH'($urandom_range(1, 1000)) : WIDTH'($urandom);
            start_op(1'(i % 3 != 0), a, b, 1'b1, $sformatf("rand%0d", i));
            wait_done(0, '0, '0);
        end

        check("sb_drained", 64'(scoreboard.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative divide controller for the multi-cycle CPU; replaces the single-edge, fully unrolled divide.
- Accepts one DIV/DIVU request from the main control FSM and latches the operands.
- Runs a radix-2 restoring divide over several cycles, applies the sign fix-up, and returns quotient/remainder with a one-cycle done pulse.
- Provides the busy signal the control FSM uses to stall.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STEPS, 1, quotient bits retired per ITER cycle; legal values 1, 2, 4; WIDTH % STEPS == 0.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled in IDLE and DONE only.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  in  WIDTH  sampled with start.
- divisor  in  WIDTH  sampled with start.
- cancel  in  1  flush request from control FSM (exception/branch squash).
- busy  out  1  high while an operation is in flight (ITER, FIX).
- done  out  1  one-cycle pulse; q/r/div_by_zero valid.
- q  out  WIDTH  quotient; holds until the next done.
- r  out  WIDTH  remainder; holds until the next done.
- div_by_zero  out  1  flag for the last completed operation; holds until the next done.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high; ports are named clock and reset.
- Reset values: state=IDLE, busy=0, done=0, q=0, r=0, div_by_zero=0, iteration counter=0.
- States: IDLE, ITER, FIX, DONE.
- IDLE or DONE with start=1:
  - latch is_signed, the operand sign bits and the magnitudes: abs() when is_signed, raw value otherwise.
  - clear the remainder accumulator; counter=0.
  - divisor != 0: go to ITER.
  - divisor == 0: go to FIX with the dbz flag set.
- ITER:
  - per cycle, shift {rem,quo} left and subtract the divisor magnitude when rem >= magnitude; the quotient bit is 1 when subtracted. Repeat STEPS times.
  - counter += STEPS; leave for FIX when the counter reaches WIDTH.
  - ITER lasts exactly WIDTH/STEPS cycles.
- FIX (1 cycle), writes q/r/div_by_zero registers:
  - signed, operand signs differ: q = -quo.
  - signed, dividend negative: r = -rem (remainder takes the dividend's sign).
  - otherwise q = quo, r = rem.
  - div-by-zero: q = all ones, r = original dividend (unmodified), div_by_zero=1. This applies in both signed and unsigned modes.
  - signed overflow 0x80000000 / 0xFFFFFFFF: q = 0x80000000, r = 0, no flag. This falls out of WIDTH-bit wrap of the magnitude arithmetic.
- DONE (1 cycle):
  - done=1, busy=0.
  - start → new op (back-to-back, no bubble); else → IDLE.
- busy: 1 in ITER and FIX, 0 in IDLE and DONE.
- Latency: start sampled at edge 0 → done high in cycle WIDTH/STEPS+2 (34 for defaults); div-by-zero → done in cycle 2.
- start while busy: ignored; operands are not re-latched.
- cancel (any state, highest priority after reset):
  - next state IDLE, busy=0 next cycle, no done pulse.
  - q/r/div_by_zero keep their previous values.
  - cancel and start in the same cycle: cancel wins, start dropped.
- Reset mid-operation: immediate return to reset values; no done.
- Arithmetic: remainder accumulator is WIDTH+1 bits, to hold the shifted value before the compare. All negation is modulo 2^WIDTH.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, ITER, FIX, DONE}.
  - DIV_WIDTH_DEFAULT=32.
  - DBZ_QUOTIENT = all ones.
  - function abs_mag(value, is_signed).
- Sub-module div_step: combinational, parameterised by WIDTH and STEPS. Takes {rem, quo, divisor magnitude} and returns the next {rem, quo} after STEPS restoring steps. It is instantiated once in ITER.
- Sequencing, latching and sign fix-up stay in div_sequencer.

Test Plan:
- Unsigned 100/7 (is_signed=0), start at cycle 0 → busy cycles 1–33, done in cycle 34, q=14, r=2, div_by_zero=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → q=0xFFFFFFFD, r=0xFFFFFFFF. Then 7/-2 → q=0xFFFFFFFD, r=1.
- Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, div_by_zero=0. Unsigned 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- Divide by zero, signed 0xFFFFFFF9 / 0 → done in cycle 2, q=0xFFFFFFFF, r=0xFFFFFFF9, div_by_zero=1.
- Complete 100/7, then start 9/4 in the DONE cycle → second done exactly 34 cycles later with q=2, r=1. A start pulsed at cycle 10 of the second op is ignored.
- Cancel at cycle 10 of 50/5, after a prior result of q=14, r=2:
  - busy=0 at cycle 11; no done pulse.
  - q=14, r=2 retained.
  - Repeat the same op with reset at cycle 10 → all outputs 0 immediately.
